ring_counter_checker: RTL

Downstream integrity monitor for the n-bit left/right ring counter. It samples the counter's parallel output each clock0 cycle, predicts the next value from the previous sample and the previous shift direction, and flags any deviation. It acquires lock after a run of correct transitions and keeps a saturating error count plus a sticky flag. Its outputs go to the status/debug register bank.

---
 rtl/ring_counter_checker_if.sv | 27 ++
 rtl/ring_counter_checker.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ring_counter_checker_if.sv
// Status/monitor bundle between the ring counter checker and its surroundings.
// The top-level testbench or register bank uses the master side; the checker uses the slave side.
interface ring_counter_checker_if #(
  parameter int WIDTH     = 200,
  parameter int ERR_CNT_W = 16
);
  logic                 ring_reset;
  logic                 lr;
  logic                 check_en;
  logic                 clear_errors;
  logic [WIDTH-1:0]     ring_in;
  logic                 locked;
  logic                 error_pulse;
  logic                 sticky_error;
  logic [ERR_CNT_W-1:0] error_count;
  logic                 onehot_error;

  modport master (
    output ring_reset, lr, check_en, clear_errors, ring_in,
    input  locked, error_pulse, sticky_error, error_count, onehot_error
  );

  modport slave (
    input  ring_reset, lr, check_en, clear_errors, ring_in,
    output locked, error_pulse, sticky_error, error_count, onehot_error
  );
endinterface

// File: rtl/ring_counter_checker.sv
// Integrity monitor for the left/right ring counter: predicts each sample, locks, counts errors.
// Optional one-hot violation flag enabled by defining RING_CHECKER_ONEHOT_EN.
module ring_counter_checker #(
  parameter int WIDTH      = 200,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                   clock0,
  input  logic                   reset,
  ring_counter_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  localparam logic [WIDTH-1:0] SEED      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t           state, state_d;
  logic [3:0]       run, run_d;
  logic [WIDTH-1:0] sample_q;
  logic             lr_q;
  logic             rst_q;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic             err;

  always_comb begin
    if (rst_q)
      expected = SEED;
    else if (lr_q)
      expected = {sample_q[WIDTH-2:0], sample_q[WIDTH-1]};
    else
      expected = {sample_q[0], sample_q[WIDTH-1:1]};
  end

  assign match = (bus.ring_in == expected);

  always_comb begin
    state_d = state;
    run_d   = run;
    err     = 1'b0;
    case (state)
      IDLE: begin
        run_d = '0;
        if (bus.check_en)
          state_d = SEARCH;
      end
      SEARCH: begin
        if (!bus.check_en) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (match) begin
          if (run + 4'd1 == LOCK_CNT4) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run + 4'd1;
          end
        end else begin
          run_d = '0;
        end
      end
      LOCKED: begin
        if (!bus.check_en) begin
          state_d = IDLE;
        end else if (!match) begin
          err     = 1'b1;
          state_d = SEARCH;
          run_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      run      <= '0;
      sample_q <= '0;
      lr_q     <= 1'b0;
      rst_q    <= 1'b0;
    end else begin
      state    <= state_d;
      run      <= run_d;
      sample_q <= bus.ring_in;
      lr_q     <= bus.lr;
      rst_q    <= bus.ring_reset;
    end
  end

  // A detection in the same cycle as clear_errors restarts the count at one.
  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      bus.error_pulse  <= 1'b0;
      bus.sticky_error <= 1'b0;
      bus.error_count  <= '0;
    end else begin
      bus.error_pulse <= err;
      if (err) begin
        bus.sticky_error <= 1'b1;
        if (bus.clear_errors)
          bus.error_count <= {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        else if (bus.error_count != '1)
          bus.error_count <= bus.error_count + 1'b1;
      end else if (bus.clear_errors) begin
        bus.sticky_error <= 1'b0;
        bus.error_count  <= '0;
      end
    end
  end

  assign bus.locked = (state == LOCKED);

`ifdef RING_CHECKER_ONEHOT_EN
  logic [WIDTH-1:0] ring_m1;
  logic             is_onehot;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign ring_m1   = bus.ring_in - 1'b1;
  assign is_onehot = (bus.ring_in != '0) && ((bus.ring_in & ring_m1) == '0);

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset)
      bus.onehot_error <= 1'b0;
    else
      bus.onehot_error <= bus.check_en & ~is_onehot;
  end
`else
  assign bus.onehot_error = 1'b0;
`endif

endmodule
